// File: rtl/axi_v_mem_responder.sv
// AXI4 INCR-burst memory responder for the vector memory subsystem.
// Independent write (AW/W/B) and read (AR/R) engines share one beat-wide
// storage array. Responses are always OKAY, so no resp signals exist.
// Ports:
//   clk, rstn          - clock, synchronous active-low reset
//   s_axi_aw*          - write address (valid/ready/addr/len)
//   s_axi_w*           - write data (valid/ready/data/strb/last)
//   s_axi_b*           - write response (valid/ready)
//   s_axi_ar*          - read address (valid/ready/addr/len)
//   s_axi_r*           - read data (valid/ready/data/last)
//   wlast_err_o        - sticky flag: wlast disagreed with the beat count
module axi_v_mem_responder #(
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned MEM_WORDS          = 1024
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]                      s_axi_awlen,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wlast,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]                      s_axi_arlen,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic                            s_axi_rlast,
   output logic                            wlast_err_o
);

   localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned OffW  = $clog2(StrbW);
   localparam int unsigned IdxW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   typedef logic [IdxW-1:0] idx_t;

   // Byte address to word index; truncation to IdxW bits gives the wrap.
   function automatic idx_t to_idx(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
      return idx_t'(addr >> OffW);
   endfunction

   logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

   // ---------------------------------------------------------------- write
   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   w_state_e w_state_q, w_state_d;

   logic       awready_q, awready_d;
   logic       wready_q, wready_d;
   logic       bvalid_q, bvalid_d;
   logic       wlast_err_q;
   idx_t       w_idx_q;
   logic [7:0] w_len_q, w_cnt_q;
   logic       aw_hs, w_hs, b_hs, w_final;

   assign aw_hs   = s_axi_awvalid & awready_q;
   assign w_hs    = s_axi_wvalid & wready_q;
   assign b_hs    = bvalid_q & s_axi_bready;
   assign w_final = (w_cnt_q == w_len_q);

   always_comb begin
      w_state_d = w_state_q;
      unique case (w_state_q)
         WIdle:   if (aw_hs) w_state_d = WData;
         WData:   if (w_hs && w_final) w_state_d = WResp;
         WResp:   if (b_hs) w_state_d = WIdle;
         default: w_state_d = WIdle;
      endcase
   end

   // Handshake outputs are registered copies of the next state.
   always_comb begin
      awready_d = (w_state_d == WIdle);
      wready_d  = (w_state_d == WData);
      bvalid_d  = (w_state_d == WResp);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         w_state_q   <= WIdle;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         wlast_err_q <= 1'b0;
         w_idx_q     <= '0;
         w_len_q     <= '0;
         w_cnt_q     <= '0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         if (aw_hs) begin
            w_idx_q <= to_idx(s_axi_awaddr);
            w_len_q <= s_axi_awlen;
            w_cnt_q <= '0;
         end else if (w_hs) begin
            w_idx_q <= w_idx_q + 1'b1;
            w_cnt_q <= w_cnt_q + 8'd1;
            // Burst length comes from awlen; wlast is only cross-checked.
            if (s_axi_wlast != w_final) wlast_err_q <= 1'b1;
         end
      end
   end

   // Storage has no reset so contents survive a mid-burst reset.
   always_ff @(posedge clk) begin
      if (rstn && w_hs) begin
         for (int i = 0; i < StrbW; i++) begin
            if (s_axi_wstrb[i]) mem[w_idx_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
         end
      end
   end

   // ----------------------------------------------------------------- read
   typedef enum logic {RIdle, RData} r_state_e;
   r_state_e r_state_q, r_state_d;

   logic                          arready_q, arready_d;
   logic                          rvalid_q, rvalid_d;
   logic                          rlast_q, rlast_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
   idx_t                          r_idx_q;  // index of the next beat to fetch
   logic [7:0]                    r_len_q, r_cnt_q;
   logic                          ar_hs, r_hs, r_final;

   assign ar_hs   = s_axi_arvalid & arready_q;
   assign r_hs    = rvalid_q & s_axi_rready;
   assign r_final = (r_cnt_q == r_len_q);

   always_comb begin
      r_state_d = r_state_q;
      unique case (r_state_q)
         RIdle:   if (ar_hs) r_state_d = RData;
         RData:   if (r_hs && r_final) r_state_d = RIdle;
         default: r_state_d = RIdle;
      endcase
   end

   always_comb begin
      arready_d = (r_state_d == RIdle);
      rvalid_d  = (r_state_d == RData);
      rlast_d   = rlast_q;
      if (ar_hs) begin
         rlast_d = (s_axi_arlen == 8'd0);
      end else if (r_hs) begin
         rlast_d = !r_final && ((r_cnt_q + 8'd1) == r_len_q);
      end
   end

   // Reads sample mem before this edge's write lands: old data on a collision.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state_q <= RIdle;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         if (ar_hs) begin
            rdata_q <= mem[to_idx(s_axi_araddr)];
            r_idx_q <= to_idx(s_axi_araddr) + 1'b1;
            r_len_q <= s_axi_arlen;
            r_cnt_q <= '0;
         end else if (r_hs && !r_final) begin
            rdata_q <= mem[r_idx_q];
            r_idx_q <= r_idx_q + 1'b1;
            r_cnt_q <= r_cnt_q + 8'd1;
         end
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rlast   = rlast_q;
   assign wlast_err_o   = wlast_err_q;

endmodule

// File: doc/axi_v_mem_responder.md
AXI_V_MEM_RESPONDER -- requirements
Module: axi_v_mem_responder

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, AXI byte-address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, beat width; legal values are 32 and 64.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, storage depth in beats; must be a power of 2.
REQ-004 SHALL have one clock, `clk`, with a synchronous active-low reset, `rstn`.
REQ-005 SHALL have ports, listed as name, direction, width, meaning:
- `clk`, in, 1, sole clock; all state changes on its rising edge.
- `rstn`, in, 1, synchronous reset, active low.
- `s_axi_awvalid`, in, 1, write-address valid.
- `s_axi_awready`, out, 1, write-address ready.
- `s_axi_awaddr`, in, C_S_AXI_ADDR_WIDTH, write burst start byte address.
- `s_axi_awlen`, in, 8, write beats minus 1.
- `s_axi_wvalid`, in, 1, write-data valid.
- `s_axi_wready`, out, 1, write-data ready.
- `s_axi_wdata`, in, C_S_AXI_DATA_WIDTH, write beat data.
- `s_axi_wstrb`, in, C_S_AXI_DATA_WIDTH/8, byte enables.
- `s_axi_wlast`, in, 1, last write beat flag.
- `s_axi_bvalid`, out, 1, write response valid.
- `s_axi_bready`, in, 1, write response ready.
- `s_axi_arvalid`, in, 1, read-address valid.
- `s_axi_arready`, out, 1, read-address ready.
- `s_axi_araddr`, in, C_S_AXI_ADDR_WIDTH, read burst start byte address.
- `s_axi_arlen`, in, 8, read beats minus 1.
- `s_axi_rvalid`, out, 1, read-data valid.
- `s_axi_rready`, in, 1, read-data ready.
- `s_axi_rdata`, out, C_S_AXI_DATA_WIDTH, read beat data.
- `s_axi_rlast`, out, 1, last read beat flag.
- `wlast_err_o`, out, 1, sticky wlast-protocol error flag.
REQ-006 SHALL be the responder for the reduced AXI4 master subset the vector memory subsystem drives: INCR bursts only, no id/size/burst/resp/prot signals; the response is always OKAY.

Function
REQ-007 SHALL hold storage as MEM_WORDS beats; word index = (addr >> log2(C_S_AXI_DATA_WIDTH/8)) mod MEM_WORDS. Address bits below the beat boundary are ignored.
REQ-008 SHALL advance the index by 1 per beat within a burst and wrap from MEM_WORDS-1 to 0.
REQ-009 SHALL run the write FSM with states W_IDLE, W_DATA, W_RESP, transitioning W_IDLE->W_DATA on AW handshake, W_DATA->W_RESP on the accepted beat number awlen+1, and W_RESP->W_IDLE on bvalid&&bready.
REQ-010 SHALL drive s_axi_awready=1 only in W_IDLE, s_axi_wready=1 only in W_DATA, and s_axi_bvalid=1 only in W_RESP; all three are registered.
REQ-011 SHALL latch awaddr and awlen on the AW handshake; no W beat is accepted in the handshake cycle.
REQ-012 SHALL, on each W handshake, write byte lane i of the current word iff wstrb[i]=1; lanes with wstrb[i]=0 are unchanged.
REQ-013 SHALL end the burst by beat count only; if wlast=1 on a non-final beat or wlast=0 on the final beat, set wlast_err_o=1 (sticky until reset) and still complete after awlen+1 beats.
REQ-014 SHALL hold bvalid until bready; awready returns to 1 in the cycle after the B handshake.
REQ-015 SHALL run the read FSM with states R_IDLE and R_DATA, independent of and concurrent with the write FSM.
REQ-016 SHALL drive s_axi_arready=1 only in R_IDLE; on AR handshake it SHALL latch arlen, register rdata=mem[index], and set rvalid=1 on the next cycle (1-cycle AR-to-R latency).
REQ-017 SHALL hold rdata, rvalid and rlast stable while rvalid=1 and rready=0.
REQ-018 SHALL, on an R handshake of a non-final beat, register rdata=mem[index+1]; the following cycle presents that beat with rvalid=1 (no bubble).
REQ-019 SHALL assert rlast exactly on beat arlen; on its handshake rvalid drops to 0 and the FSM returns to R_IDLE, with arready=1 in the next cycle.
REQ-020 SHALL return the pre-write contents when a read capture and a write to the same word occur in the same cycle.
REQ-021 SHALL treat awlen=0 and arlen=0 as single-beat bursts with wlast/rlast on beat 0.

Reset
REQ-022 SHALL, while rstn=0 at a clock edge, force both FSMs to idle and drive awready, wready, bvalid, arready, rvalid, rlast, wlast_err_o to 0 and rdata to 0.
REQ-023 SHALL, after a reset asserted mid-burst, abandon the burst with no B response and no further R beats; memory contents are retained, not cleared.
REQ-024 SHALL raise awready and arready on the first edge after rstn returns to 1.

Verification
REQ-025 SHALL cover: AW addr 0x10, awlen=3, data 1..4, wstrb=0xF; then AR 0x10, arlen=3 -> exactly one B; R returns 1,2,3,4 with rlast on beat 4.
REQ-026 SHALL cover: word 0x04 holding 0xAABBCCDD, write 0x11223344 with wstrb=0x5 -> readback 0xAA22CC44.
REQ-027 SHALL cover: burst starting at word MEM_WORDS-2, len 4 -> the last 2 beats land at words 0 and 1; readback matches.
REQ-028 SHALL cover: rready toggling 1/0 every cycle over 8 beats -> rdata stable while stalled, no beat lost or duplicated; wlast asserted on beat 2 of a 4-beat burst -> wlast_err_o=1 and B issued after beat 4.
REQ-029 SHALL cover: concurrent 16-beat write and read to disjoint regions, bready held 0 for 5 cycles -> bvalid held; read completes unaffected.
REQ-030 SHALL cover: rstn pulsed low at read beat 2 of 8 -> rvalid=0 at the next edge, arready=1 on the first edge after release, and previously written data intact.
